difetto_obsr_seq: RTL and testbench
===================================

Name: difetto_obsr_seq

Overview:
- Output boundary-scan register with a built-in capture/shift/update sequencer. It is the pad-side counterpart of the input boundary-scan register.
- In functional mode it passes core outputs D straight to pad outputs Q.
- In test mode Q is driven from an update register. That register is loaded by serially shifting a WIDTH-bit vector in on SI. The previously captured core values shift out on SO at the same time.
- Inserted by the boundary-scan pass between each core output port and the top-level pad. Marked no_boundary_scan and keep_hierarchy.

Parameters:
- WIDTH, 1, number of boundary bits (>= 1).
- CLK_POLARITY, 1'b1, active clock edge (1 = rising, 0 = falling).
- TEST_POLARITY, 1'b1, TEST level that selects test mode.

Ports:
- CLK  input  1  clock; edge per CLK_POLARITY.
- RESET_N  input  1  asynchronous, active-low reset.
- TEST  input  1  mode select; test mode when TEST == TEST_POLARITY.
- START  input  1  single-cycle request to run one capture/shift/update sequence.
- SI  input  1  serial scan in; sampled during SHIFT.
- D  input  WIDTH  functional values from the core.
- Q  output  WIDTH  pad values.
- SO  output  1  serial scan out; equals shift_reg[0], combinational from the register.
- BUSY  output  1  high whenever state != IDLE.
- DONE  output  1  registered one-cycle pulse after the UPDATE edge.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - state = IDLE, cnt = 0, shift_reg = 0, upd_reg = 0, DONE = 0.
  - Consequently BUSY = 0 and SO = 0.
  - Q = D when not in test mode, else 0.
  - Release is synchronous to the next active edge.
- Q mux is combinational and independent of state:
  - Q = upd_reg when TEST == TEST_POLARITY, else Q = D.
- States: IDLE, CAPTURE, SHIFT, UPDATE. All transitions occur on the active edge.
  - IDLE: START = 1 goes to CAPTURE; otherwise stay.
  - CAPTURE: shift_reg <= D; cnt <= 0; go to SHIFT.
  - SHIFT: shift_reg <= {SI, shift_reg[WIDTH-1:1]}; cnt <= cnt + 1. When cnt == WIDTH-1 on this edge, go to UPDATE.
  - UPDATE: upd_reg <= shift_reg; DONE <= 1; go to IDLE.
- DONE is cleared on every edge where it was not just set.
- Timing from the START edge:
  - exactly WIDTH+2 edges until BUSY falls;
  - DONE rises in the same cycle that BUSY falls.
- Bit order: LSB first on both SO and SI.
  - SO shows D[0] (as captured) during the first SHIFT cycle.
  - The first SI bit sampled ends at upd_reg[0]; the last ends at upd_reg[WIDTH-1].
- cnt width is $clog2(WIDTH+1). Never wraps; it is only compared against WIDTH-1.
- WIDTH = 1: SHIFT lasts exactly one edge.
- START while BUSY: ignored and not queued.
- START on the same edge that DONE is set (UPDATE -> IDLE): ignored, because the state at that edge is UPDATE.
- START while RESET_N is low: ignored.
- TEST toggled mid-sequence:
  - The sequence continues unaffected.
  - Only the Q mux changes, immediately (combinationally).
- upd_reg holds its value between sequences and across TEST toggles. Only reset or UPDATE alter it.
- Reset asserted mid-sequence:
  - Sequence aborted; all registers take their reset values.
  - No DONE pulse is produced.
  - upd_reg is cleared even if it was loaded by an earlier sequence.

Decomposition:
- Shared package difetto_bsr_pkg holds:
  - state encoding constants (IDLE = 2'd0, CAPTURE = 2'd1, SHIFT = 2'd2, UPDATE = 2'd3);
  - the function computing the cnt width.
  - The input-side register reuses this package.
- One natural sub-module: difetto_obsr_cell, instantiated WIDTH times as a chain. Per bit it contains:
  - the shift flop with its capture/shift mux;
  - the update flop;
  - the Q mux.
  - Control inputs: capture_en, shift_en, update_en.
- The sequencer (state, cnt, BUSY, DONE) stays in difetto_obsr_seq.

Test Plan:
- Reset check: assert RESET_N = 0 mid-clock with TEST = 0, D = 4'b0110, then TEST = 1. Required: Q = 0110, then Q = 0000; SO = 0, BUSY = 0, DONE = 0, all without waiting for a clock edge.
- Basic sequence: WIDTH = 4, TEST = 1, D = 4'b1010, START pulse, SI = 1,1,0,0 over the SHIFT cycles. Required:
  - SO = 0,1,0,1;
  - BUSY high for 6 cycles, DONE pulses once;
  - afterwards Q = 4'b0011, and D changes do not affect Q.
- Mode toggle: after the basic sequence, set TEST = 0 with D = 4'b1111. Required: Q = 1111. Then set TEST = 1; required: Q = 0011 again (upd_reg retained).
- Ignored START: pulse START during SHIFT, and again in the cycle DONE is set. Required: no second sequence, BUSY stays low after DONE, upd_reg unchanged.
- Reset mid-sequence: deassert RESET_N at the second SHIFT cycle, release it, then pulse START with SI = 1,0,0,0. Required:
  - no DONE during the aborted run;
  - the new run completes normally with Q = 4'b0001 (TEST = 1).
- Parameter corner: WIDTH = 1 with CLK_POLARITY = 0 and TEST_POLARITY = 0. START on a falling edge, D = 1, SI = 0. Required:
  - SO = 1 during SHIFT;
  - DONE after 3 falling edges;
  - Q = 0 while TEST = 0, and Q = D when TEST = 1.

Source files
------------

// File: rtl/difetto_bsr_pkg.sv
// Shared definitions for the difetto input/output boundary-scan registers:
// sequencer state encoding and the counter width helper.
package difetto_bsr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SHIFT   = 2'd2,
    UPDATE  = 2'd3
  } bsr_state_t;

  // Counter must hold 0..width without wrapping.
  function automatic int unsigned bsr_cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/difetto_obsr_cell.sv
// One output boundary-scan bit: capture/shift flop, update flop and pad mux.
module difetto_obsr_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic test_mode,
  input  logic capture_en,
  input  logic shift_en,
  input  logic update_en,
  input  logic d,
  input  logic si,
  output logic q,
  output logic so
);

  logic shift_q;
  logic upd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= 1'b0;
    end else if (capture_en) begin
      shift_q <= d;
    end else if (shift_en) begin
      shift_q <= si;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_q <= 1'b0;
    end else if (update_en) begin
      upd_q <= shift_q;
    end
  end

  assign q  = test_mode ? upd_q : d;
  assign so = shift_q;

endmodule

// File: rtl/difetto_obsr_seq.sv
// Output boundary-scan register with built-in capture/shift/update sequencer.
// Functional mode passes D to Q; test mode drives Q from the update register.
module difetto_obsr_seq
  import difetto_bsr_pkg::*;
#(
  parameter int unsigned WIDTH         = 1,
  parameter logic        CLK_POLARITY  = 1'b1,
  parameter logic        TEST_POLARITY = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             TEST,
  input  logic             START,
  input  logic             SI,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             SO,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned   CW       = bsr_cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  // Falling-edge variants run the same posedge logic on an inverted clock.
  logic aclk;
  assign aclk = CLK_POLARITY ? CLK : ~CLK;

  logic test_mode;
  assign test_mode = (TEST == TEST_POLARITY);

  bsr_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          done_nxt;
  logic          capture_en, shift_en, update_en;

  always_ff @(posedge aclk or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      cnt   <= '0;
      DONE  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      DONE  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    done_nxt   = 1'b0;
    capture_en = 1'b0;
    shift_en   = 1'b0;
    update_en  = 1'b0;
    case (state)
      IDLE: begin
        if (START) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        capture_en = 1'b1;
        cnt_nxt    = '0;
        state_nxt  = SHIFT;
      end
      SHIFT: begin
        shift_en = 1'b1;
        cnt_nxt  = cnt + CW'(1);
        if (cnt == CNT_LAST) state_nxt = UPDATE;
      end
      UPDATE: begin
        update_en = 1'b1;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign BUSY = (state != IDLE);

  // Chain shifts toward bit 0: SI enters at the top, SO leaves from bit 0.
  logic [WIDTH-1:0] chain_so;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic cell_si;
    if (i == WIDTH - 1) begin : g_top
      assign cell_si = SI;
    end else begin : g_mid
      assign cell_si = chain_so[i+1];
    end

    difetto_obsr_cell u_cell (
      .clk        (aclk),
      .rst_n      (RESET_N),
      .test_mode  (test_mode),
      .capture_en (capture_en),
      .shift_en   (shift_en),
      .update_en  (update_en),
      .d          (D[i]),
      .si         (cell_si),
      .q          (Q[i]),
      .so         (chain_so[i])
    );
  end

  assign SO = chain_so[0];

endmodule

// File: tb/tb_difetto_obsr_seq.sv
// Scoreboard bench: WIDTH=4 rising-edge instance plus WIDTH=1 falling-edge,
// inverted-TEST instance.
`timescale 1ns/1ps
module tb_difetto_obsr_seq;

  logic clk = 1'b0;

  logic       rst4_n, test4, start4, si4;
  logic [3:0] d4, q4;
  logic       so4, busy4, done4;

  logic       rst1_n, test1, start1, si1;
  logic [0:0] d1, q1;
  logic       so1, busy1, done1;

  int n_chk  = 0;
  int n_pass = 0;

  logic [3:0] sb4[$];
  logic       sb1[$];
  logic [3:0] exp4_m;
  logic       exp1_m;
  int         busy_run  = 0;
  logic       busy_prev = 1'b0;
  int         done_cnt4 = 0;

  difetto_obsr_seq #(.WIDTH(4)) u4 (
    .CLK(clk), .RESET_N(rst4_n), .TEST(test4), .START(start4), .SI(si4),
    .D(d4), .Q(q4), .SO(so4), .BUSY(busy4), .DONE(done4)
  );

  difetto_obsr_seq #(.WIDTH(1), .CLK_POLARITY(1'b0), .TEST_POLARITY(1'b0)) u1 (
    .CLK(clk), .RESET_N(rst1_n), .TEST(test1), .START(start1), .SI(si1),
    .D(d1), .Q(q1), .SO(so1), .BUSY(busy1), .DONE(done1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // WIDTH=4 monitor: busy-run length, DONE alignment, Q at each DONE.
  always @(negedge clk) begin
    if (rst4_n !== 1'b1) begin
      busy_run  = 0;
      busy_prev = 1'b0;
    end else begin
      if (busy4) begin
        busy_run++;
      end else if (busy_prev) begin
        check("busy_len", busy_run, 6);
        check("done_at_busy_fall", done4, 1'b1);
        busy_run = 0;
      end
      busy_prev = busy4;
      if (done4) begin
        done_cnt4++;
        if (sb4.size() == 0) begin
          n_chk++;
          $display("FAIL u4_unexpected_done: got DONE=1, expected no pulse (t=%0t)", $time);
        end else begin
          exp4_m = sb4.pop_front();
          check("u4_done_q", q4, exp4_m);
        end
      end
    end
  end

  // WIDTH=1 monitor (falling-edge DUT, sampled on rising edge).
  always @(posedge clk) begin
    if (rst1_n === 1'b1 && done1) begin
      if (sb1.size() == 0) begin
        n_chk++;
        $display("FAIL u1_unexpected_done: got DONE=1, expected no pulse (t=%0t)", $time);
      end else begin
        exp1_m = sb1.pop_front();
        check("u1_done_q", q1, exp1_m);
      end
    end
  end

  task automatic seq4(input logic [3:0] dv, input logic [3:0] siv, input logic [3:0] sov,
                      input logic [3:0] expq, input bit pmid, input bit pupd);
    sb4.push_back(expq);
    d4 = dv; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    check("busy_rise", busy4, 1'b1);
    @(posedge clk); #1;
    d4 = ~dv;
    for (int k = 0; k < 4; k++) begin
      check("so_bit", so4, sov[k]);
      si4    = siv[k];
      start4 = pmid && (k == 1);
      @(posedge clk); #1;
    end
    start4 = pupd;
    @(posedge clk); #1;
    start4 = 1'b0;
    check("done_pulse", done4, 1'b1);
    check("busy_fall", busy4, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      check("busy_stays_idle", busy4, 1'b0);
    end
    check("done_clear", done4, 1'b0);
    check("q_after_seq", q4, expq);
  endtask

  task automatic seq1(input logic dv, input logic siv, input logic exp_so,
                      input logic expq, input logic expq_func);
    sb1.push_back(expq);
    test1 = 1'b0; d1 = dv; start1 = 1'b1;
    @(negedge clk); #1;
    start1 = 1'b0;
    check("u1_busy_rise", busy1, 1'b1);
    @(negedge clk); #1;
    check("u1_so_shift", so1, exp_so);
    si1 = siv;
    @(negedge clk); #1;
    check("u1_no_early_done", done1, 1'b0);
    check("u1_busy_update", busy1, 1'b1);
    @(negedge clk); #1;
    check("u1_done_3_edges", done1, 1'b1);
    check("u1_busy_fall", busy1, 1'b0);
    check("u1_q_test", q1, expq);
    @(posedge clk); #1;
    test1 = 1'b1;
    #1 check("u1_q_func", q1, expq_func);
    @(negedge clk); #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got no end of run, expected finish before 50000ns");
    $fatal(1, "timeout");
  end

  initial begin
    rst4_n = 1'b1; test4 = 1'b0; start4 = 1'b0; si4 = 1'b0; d4 = 4'b0110;
    rst1_n = 1'b1; test1 = 1'b1; start1 = 1'b0; si1 = 1'b0; d1 = 1'b0;

    // Asynchronous reset mid-clock.
    #2 rst4_n = 1'b0; rst1_n = 1'b0;
    #1 check("rst_q_func", q4, 4'b0110);
    test4 = 1'b1;
    #1 check("rst_q_test", q4, 4'b0000);
    check("rst_so", so4, 1'b0);
    check("rst_busy", busy4, 1'b0);
    check("rst_done", done4, 1'b0);
    check("u1_rst_busy", busy1, 1'b0);
    check("u1_rst_so", so1, 1'b0);
    @(negedge clk);
    rst4_n = 1'b1; rst1_n = 1'b1;
    @(posedge clk); #1;

    // Basic sequence: D=1010, SI=1,1,0,0 -> SO=0,1,0,1, Q=0011.
    seq4(4'b1010, 4'b0011, 4'b1010, 4'b0011, 1'b0, 1'b0);
    d4 = 4'b0101;
    #1 check("q_ignores_d", q4, 4'b0011);
    test4 = 1'b0; d4 = 4'b1111;
    #1 check("mode_func", q4, 4'b1111);
    test4 = 1'b1;
    #1 check("mode_test_retained", q4, 4'b0011);
    @(posedge clk); #1;

    // START during SHIFT and during UPDATE must be ignored.
    seq4(4'b0110, 4'b1010, 4'b0110, 4'b1010, 1'b1, 1'b1);

    // Reset in the second SHIFT cycle aborts without DONE and clears upd_reg.
    d4 = 4'b1111; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    si4 = 1'b1;
    @(posedge clk); #1;
    rst4_n = 1'b0;
    #1 check("abort_busy", busy4, 1'b0);
    check("abort_done", done4, 1'b0);
    check("abort_upd_cleared", q4, 4'b0000);
    check("abort_so", so4, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst4_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("abort_idle", busy4, 1'b0);
    end

    // Restart after abort: SI=1,0,0,0 -> Q=0001.
    seq4(4'b1001, 4'b0001, 4'b1001, 4'b0001, 1'b0, 1'b0);

    check("u4_sb_drain", sb4.size(), 0);
    check("u4_done_count", done_cnt4, 3);

    // WIDTH=1, falling edge, TEST active low.
    @(negedge clk); #1;
    seq1(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    seq1(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("u1_sb_drain", sb1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
